// File: rtl/distribute_leaf_buffer.sv
// distribute_leaf_buffer: two independent first-word-fall-through FIFOs, one per distribute-switch branch
module distribute_leaf_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [1:0]                          i_valid,
  input  logic [2*DATA_WIDTH-1:0]             i_data_bus,
  output logic [1:0]                          o_in_ready,
  output logic [1:0]                          o_valid,
  output logic [2*DATA_WIDTH-1:0]             o_data_bus,
  input  logic [1:0]                          i_ready,
  output logic [2*($clog2(FIFO_DEPTH)+1)-1:0] o_count,
  output logic [1:0]                          o_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  for (genvar b = 0; b < 2; b++) begin : g_br
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr, rd;
    logic [CW-1:0] cnt;
    logic ovf, full, empty, push, pop;
    assign full  = cnt == CW'(FIFO_DEPTH);
    assign empty = cnt == '0;
    assign push  = i_valid[b] && !full;
    assign pop   = i_ready[b] && !empty;
    // pointers are AW bits wide, so wrap modulo the power-of-two depth is free
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        wr  <= '0;
        rd  <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else begin
        if (push) wr <= wr + AW'(1);
        if (pop) rd <= rd + AW'(1);
        cnt <= cnt + CW'(push) - CW'(pop);
        if (i_valid[b] && full) ovf <= 1'b1;
      end
    always_ff @(posedge clk)
      if (push) mem[wr] <= i_data_bus[b*DATA_WIDTH +: DATA_WIDTH];
    assign o_in_ready[b]                         = !full;
    assign o_valid[b]                            = !empty;
    assign o_data_bus[b*DATA_WIDTH +: DATA_WIDTH] = empty ? '0 : mem[rd];
    assign o_count[b*CW +: CW]                   = cnt;
    assign o_overflow[b]                         = ovf;
  end
endmodule

// File: doc/distribute_leaf_buffer.md
DISTRIBUTE_LEAF_BUFFER -- requirements
Module: distribute_leaf_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one branch word.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, entries per branch FIFO; power of two, >= 2.
REQ-003 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_valid, input, 2, per-branch valid from the upstream distribute switch; bit1 = high branch, bit0 = low branch.
REQ-006 SHALL have port i_data_bus, input, 2*DATA_WIDTH, high word [2*DATA_WIDTH-1:DATA_WIDTH], low word [DATA_WIDTH-1:0].
REQ-007 SHALL have port o_in_ready, output, 2, per-branch "not full" to upstream.
REQ-008 SHALL have port o_valid, output, 2, per-branch FIFO non-empty.
REQ-009 SHALL have port o_data_bus, output, 2*DATA_WIDTH, per-branch head word, same packing as i_data_bus.
REQ-010 SHALL have port i_ready, input, 2, per-branch consumer ready.
REQ-011 SHALL have port o_count, output, 2*($clog2(FIFO_DEPTH)+1), per-branch occupancy; high branch in the upper half.
REQ-012 SHALL have port o_overflow, output, 2, per-branch sticky drop flag.

Function
REQ-013 SHALL implement two independent FIFOs, one per branch; no interaction between branches.
REQ-014 SHALL push branch b on a clock edge iff i_valid[b]=1 and o_in_ready[b]=1.
REQ-015 SHALL drive o_in_ready[b] = (count[b] != FIFO_DEPTH) from registered state only; no combinational path from i_ready or i_valid.
REQ-016 SHALL pop branch b on a clock edge iff o_valid[b]=1 and i_ready[b]=1.
REQ-017 SHALL drive o_valid[b] = (count[b] != 0) and present the head entry first-word-fall-through.
REQ-018 SHALL drive branch b's o_data_bus slice to {DATA_WIDTH{1'b0}} whenever o_valid[b]=0 (dummy data).
REQ-019 SHALL give push-to-output latency of exactly 1 cycle: a word pushed into an empty FIFO appears with o_valid=1 in the next cycle.
REQ-020 SHALL, on simultaneous push and pop when not full, keep count unchanged and advance both pointers.
REQ-021 SHALL treat simultaneous push and pop when full as pop only; the push is not accepted because o_in_ready=0.
REQ-022 SHALL, when i_valid[b]=1 and the FIFO is full, drop the word, leave state unchanged, and set o_overflow[b]=1 until reset.
REQ-023 SHALL ignore i_ready[b] when empty; no pointer or count change and no underflow.
REQ-024 SHALL wrap read and write pointers modulo FIFO_DEPTH; count width is $clog2(FIFO_DEPTH)+1 so full and empty are distinguishable.
REQ-025 SHALL preserve FIFO order per branch across pointer wrap.

Reset
REQ-026 SHALL, while rst_n=0, immediately force pointers=0, o_count=0, o_valid=2'b00, o_overflow=2'b00, o_data_bus=0, and o_in_ready=2'b11, independent of clk.
REQ-027 SHALL discard all buffered words when reset asserts mid-operation; storage array contents need not be reset.
REQ-028 SHALL accept a push on the first rising edge after rst_n deasserts.

Verification
REQ-029 Reset: rst_n=0 asynchronously between edges with both FIFOs holding 2 words -> o_valid=00, o_count=0, o_data_bus=0, and o_in_ready=11 without waiting for a clock.
REQ-030 Duplicate: i_valid=11, data {0xAAAAAAAA,0xAAAAAAAA} for 1 cycle with i_ready=00 -> next cycle o_valid=11, both slices 0xAAAAAAAA, both counts 1.
REQ-031 Fill/overflow: i_valid=01 for 5 cycles with i_ready=00 and data 1..5 (DEPTH 4) -> low count=4, o_in_ready[0]=0, o_overflow=01; drain yields 1,2,3,4 in order.
REQ-032 Simultaneous: low FIFO at count 2 with i_valid[0]=1 and i_ready[0]=1 for 8 cycles -> count stays 2, output order matches input order across pointer wrap.
REQ-033 Full plus pop: low FIFO full with i_valid[0]=1 and i_ready[0]=1 -> one word popped, input dropped, count=3, o_overflow[0]=1.
REQ-034 Independence: i_valid=10 with 0xBBBBBBBB and i_ready=01 -> high branch buffers the word; low branch stays o_valid[0]=0 with zero data.
